// File: rtl/tl_sensor_cond.sv
// rtl/tl_sensor_cond.sv - loop-detector conditioning: sync, debounce, presence hold, stuck-on fault
module tl_sensor_cond #(
    parameter int DEB_CYCLES   = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int STUCK_CYCLES = 255,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       det_a,
    input  logic       det_al,
    input  logic       det_b,
    input  logic       det_bl,
    input  logic       clr_fault,
    output logic       Ta,
    output logic       Tal,
    output logic       Tb,
    output logic       Tbl,
    output logic [3:0] fault
);

    typedef enum logic [2:0] {
        IDLE,
        QUAL,
        ACTIVE,
        HOLD,
        FAULT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [3:0] raw;
    logic [3:0] pres;
    logic [3:0] flt;

    assign raw = {det_bl, det_b, det_al, det_a};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_ch
            logic             sync1;
            logic             sync2;
            state_t           state;
            logic [CNT_W-1:0] cnt;
            logic             t_q;
            logic             f_q;

            // t_q/f_q are updated alongside the state so outputs come straight from flops.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1 <= 1'b0;
                    sync2 <= 1'b0;
                    state <= IDLE;
                    cnt   <= CNT_ZERO;
                    t_q   <= 1'b0;
                    f_q   <= 1'b0;
                end else begin
                    sync1 <= raw[i];
                    sync2 <= sync1;
                    case (state)
                        IDLE: begin
                            if (sync2) begin
                                state <= QUAL;
                                cnt   <= CNT_ONE;
                            end
                        end
                        QUAL: begin
                            if (!sync2) begin
                                state <= IDLE;
                                cnt   <= CNT_ZERO;
                            end else if (cnt == DEB_LAST) begin
                                state <= ACTIVE;
                                cnt   <= CNT_ZERO;
                                t_q   <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        ACTIVE: begin
                            if (!sync2) begin
                                state <= HOLD;
                                cnt   <= CNT_ONE;
                            end else if (cnt == STUCK_LAST) begin
                                state <= FAULT;
                                t_q   <= 1'b0;
                                f_q   <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        HOLD: begin
                            if (sync2) begin
                                state <= ACTIVE;
                                cnt   <= CNT_ZERO;
                            end else if (cnt == HOLD_LAST) begin
                                state <= IDLE;
                                cnt   <= CNT_ZERO;
                                t_q   <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        FAULT: begin
                            // A detector still reading high cannot be cleared.
                            if (!sync2 && clr_fault) begin
                                state <= IDLE;
                                cnt   <= CNT_ZERO;
                                f_q   <= 1'b0;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            cnt   <= CNT_ZERO;
                            t_q   <= 1'b0;
                            f_q   <= 1'b0;
                        end
                    endcase
                end
            end

            assign pres[i] = t_q;
            assign flt[i]  = f_q;
        end
    endgenerate

    assign Ta    = pres[0];
    assign Tal   = pres[1];
    assign Tb    = pres[2];
    assign Tbl   = pres[3];
    assign fault = flt;

endmodule

// File: tb/tb_tl_sensor_cond.sv
// tb/tb_tl_sensor_cond.sv - scoreboard bench for tl_sensor_cond
module tb_tl_sensor_cond;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       det_a, det_al, det_b, det_bl;
    logic       clr_fault;
    logic       Ta, Tal, Tb, Tbl;
    logic [3:0] fault;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         c;
        logic [7:0] vec;
    } exp_t;
    exp_t exp_q[$];

    tl_sensor_cond dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .det_a     (det_a),
        .det_al    (det_al),
        .det_b     (det_b),
        .det_bl    (det_bl),
        .clr_fault (clr_fault),
        .Ta        (Ta),
        .Tal       (Tal),
        .Tb        (Tb),
        .Tbl       (Tbl),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output vector {fault, Tbl, Tb, Tal, Ta}; every change must match the next expected event.
    logic [7:0] prev_vec = 8'h00;
    always @(negedge clk) begin
        logic [7:0] cur;
        exp_t e;
        cur = {fault, Tbl, Tb, Tal, Ta};
        if (mon_en && cur !== prev_vec) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, cur, prev_vec);
            end else begin
                e = exp_q.pop_front();
                if (e.c != cyc || e.vec !== cur) begin
                    errors++;
                    $display("FAIL event got cyc=%0d vec=%h expected cyc=%0d vec=%h",
                             cyc, cur, e.c, e.vec);
                end
            end
            prev_vec = cur;
        end
    end

    task automatic push(input int c, input logic [7:0] v);
        exp_t e;
        e.c   = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    int n;

    initial begin
        reset_n   = 1'b0;
        clr_fault = 1'b0;
        {det_bl, det_b, det_al, det_a} = 4'hF;
        repeat (3) @(negedge clk);
        check("reset_Ta",    {7'd0, Ta},  8'h00);
        check("reset_Tal",   {7'd0, Tal}, 8'h00);
        check("reset_Tb",    {7'd0, Tb},  8'h00);
        check("reset_Tbl",   {7'd0, Tbl}, 8'h00);
        check("reset_fault", {4'd0, fault}, 8'h00);

        // Release reset with all detectors high
        mon_en = 1'b1;
        n = cyc;
        reset_n = 1'b1;
        push(n + 6, 8'h0F);
        at(n + 10);
        {det_bl, det_b, det_al, det_a} = 4'h0;
        push(n + 21, 8'h00);
        at(n + 30);

        // Debounce reject: 3-cycle pulse, then a 4-cycle pulse that must qualify
        n = cyc;
        det_a = 1'b1;
        at(n + 3);
        det_a = 1'b0;
        at(n + 25);
        n = cyc;
        det_a = 1'b1;
        push(n + 6, 8'h01);
        at(n + 4);
        det_a = 1'b0;
        push(n + 15, 8'h00);
        at(n + 25);

        // Hold extension across a 5-cycle dropout
        n = cyc;
        det_b = 1'b1;
        push(n + 6, 8'h04);
        at(n + 20);
        det_b = 1'b0;
        at(n + 25);
        det_b = 1'b1;
        at(n + 35);
        det_b = 1'b0;
        push(n + 46, 8'h00);
        at(n + 55);

        // Stuck-on fault on A-left, clear ignored while high, accepted once low
        n = cyc;
        det_al = 1'b1;
        push(n + 6, 8'h02);
        push(n + 261, 8'h20);
        at(n + 270);
        clr_fault = 1'b1;
        at(n + 271);
        clr_fault = 1'b0;
        at(n + 280);
        det_al = 1'b0;
        at(n + 290);
        clr_fault = 1'b1;
        push(n + 291, 8'h00);
        at(n + 291);
        clr_fault = 1'b0;
        at(n + 300);

        // Independence: A through and B left with different patterns
        n = cyc;
        det_a = 1'b1;
        push(n + 6, 8'h01);
        at(n + 2);
        det_bl = 1'b1;
        at(n + 5);
        det_bl = 1'b0;
        at(n + 8);
        det_a = 1'b0;
        at(n + 10);
        det_bl = 1'b1;
        push(n + 16, 8'h09);
        push(n + 19, 8'h08);
        at(n + 16);
        det_bl = 1'b0;
        push(n + 27, 8'h00);
        at(n + 35);

        // Async reset pulse while A is in HOLD
        n = cyc;
        det_a = 1'b1;
        push(n + 6, 8'h01);
        at(n + 10);
        det_a = 1'b0;
        at(n + 14);
        push(n + 15, 8'h00);
        #1 reset_n = 1'b0;
        #1 check("async_reset_Ta", {7'd0, Ta}, 8'h00);
        #1 reset_n = 1'b1;
        at(n + 20);
        det_a = 1'b1;
        push(n + 26, 8'h01);
        at(n + 30);
        det_a = 1'b0;
        push(n + 41, 8'h00);
        at(n + 45);

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tl_sensor_cond.md
Name: tl_sensor_cond

Overview:
- Conditions four raw inductive-loop detector inputs into the clean traffic-presence signals Ta, Tal, Tb, Tbl consumed directly by the left-turn traffic-light controller.
- Per channel it provides:
  - a 2-FF synchronizer;
  - a debounce qualifier;
  - a presence-hold extension, so a gap between cars does not end a green phase early;
  - stuck-on fault detection. A failed detector forces presence low, so the controller cannot be starved in one phase.

Parameters:
- DEB_CYCLES, 4, consecutive synchronized-high samples required to assert presence (>=2).
- HOLD_CYCLES, 8, cycles presence is extended after the synchronized input drops (>=1).
- STUCK_CYCLES, 255, continuous ACTIVE cycles with input high that declare a stuck-on fault.
- CNT_W, 8, per-channel counter width; must hold max(DEB_CYCLES, HOLD_CYCLES, STUCK_CYCLES).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- det_a  input  1  raw detector, street A through (asynchronous to clk)
- det_al  input  1  raw detector, street A left-turn lane
- det_b  input  1  raw detector, street B through
- det_bl  input  1  raw detector, street B left-turn lane
- clr_fault  input  1  synchronous request to clear latched faults
- Ta  output  1  conditioned presence, street A through
- Tal  output  1  conditioned presence, A left
- Tb  output  1  conditioned presence, B through
- Tbl  output  1  conditioned presence, B left
- fault  output  4  per-channel stuck-on flag: {bl, b, al, a} = bits [3:0]

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - Reset clears both sync flops, all counters and all outputs (Ta/Tal/Tb/Tbl=0, fault=4'b0000).
  - Every channel FSM returns to IDLE.
  - Reset mid-operation (any state, including FAULT) has the same effect immediately.
- Channels: four identical, independent channels; no cross-channel interaction.
- Synchronizer: s = 2-FF synchronized raw input.
- FSM per channel: IDLE, QUAL, ACTIVE, HOLD, FAULT. Counter cnt is CNT_W bits. All transitions occur on posedge clk.
  - IDLE:
    - s=1 -> QUAL, cnt=1.
  - QUAL:
    - s=0 -> IDLE, cnt=0.
    - else cnt==DEB_CYCLES-1 -> ACTIVE, cnt=0.
    - else cnt+1.
  - ACTIVE:
    - s=0 -> HOLD, cnt=1.
    - else cnt==STUCK_CYCLES-1 -> FAULT.
    - else cnt+1.
  - HOLD:
    - s=1 -> ACTIVE, cnt=0 (stuck count restarts).
    - else cnt==HOLD_CYCLES -> IDLE, cnt=0.
    - else cnt+1.
  - FAULT:
    - s=0 and clr_fault=1 -> IDLE, cnt=0.
    - otherwise stay. clr_fault while s=1 is ignored.
- Outputs: registered flops, glitch-free.
  - T=1 in ACTIVE and HOLD, 0 elsewhere.
  - fault bit=1 exactly in FAULT.
- Assert latency: raw rising, first sampled at edge k and held high -> T rises after edge k+DEB_CYCLES+1 (k+5 at default).
- Deassert latency: raw falling, first sampled low at edge j with no re-assert -> T falls after edge j+HOLD_CYCLES+2 (j+10 at default).
- Glitch rejection:
  - A raw pulse shorter than DEB_CYCLES synchronized samples never asserts T.
  - A raw dropout during HOLD keeps T high continuously.
- Counters: never wrap, since every count terminates on an equality compare before overflow.

Test Plan:
- Reset: hold reset_n=0 with all det_*=1 -> all T=0 and fault=0; release -> Ta asserts 5 cycles after the first sampling edge.
- Debounce reject: det_a high for 3 cycles then low -> Ta stays 0, FSM returns to IDLE.
- Hold extension: det_b high 20 cycles, low 5 cycles, high 10 cycles, then low -> Tb stays 1 continuously and falls 10 edges after the final low sample.
- Stuck fault: det_al held high -> Tal=1 for 255 cycles, then Tal=0 and fault[1]=1. clr_fault pulsed while det_al is still high -> no change. det_al low + clr_fault -> fault[1]=0.
- Independence: det_a and det_bl toggled with different patterns simultaneously -> each output matches its own single-channel timing.
- Async reset mid-HOLD: reset_n pulsed low for less than 1 clk period while Ta=1 in HOLD -> Ta=0 immediately, and the channel requalifies from IDLE.
